// File: rtl/decode_control.sv
// decode_control
// RV32I instruction decode and control unit for the single-cycle core.
// It decodes the current instruction into datapath selects, enables, the ALU
// opcode and the sign-extended immediate, and resolves conditional branches
// from the two register read values. A four-state machine clears and then
// loads the register file after reset, and freezes the core on ECALL/EBREAK
// (and, when DECODE_CONTROL_ILLEGAL_HALT_EN is defined, on illegal
// instructions).
//
// Configuration macro: DECODE_CONTROL_ILLEGAL_HALT_EN
//   defined   : unknown opcode/funct combinations halt the core
//   undefined : unknown encodings execute as a NOP (no writes, PC+4)
//
// Ports
//   clock                    rising-edge clock
//   reset_n                  asynchronous active-low reset
//   instruction[31:0]        current instruction word
//   REG_1/REG_2[31:0]        rs1/rs2 read data, used for branch compares
//   RF_SEL_1/_2/_RD[4:0]     rs1, rs2, rd fields
//   RF_WR_EN                 register-file write enable
//   RF_RESET / RF_SET        register-file clear / initial-value load
//   RF_DATA_IN_MUX_SEL[1:0]  0=PC+4, 1=ALU, 2=data memory
//   PC_IN_MUX_SEL            0=PC+4, 1=ALU result
//   ALU_OP_1_MUX_SEL         0=PC, 1=REG_1
//   ALU_OP_2_MUX_SEL         0=REG_2, 1=immediate
//   ALU_OPCODE[3:0]          ALU operation
//   immediate[31:0]          sign-extended immediate
//   DATA_MEMORY_WR_EN        store enable
//   DATA_MEMORY_SIZE_SEL[1:0] 0 byte, 1 half, 2 word
//   DATA_MEMORY_SIGN_EXTEND  1 = sign-extend load data
//   HALTED                   core frozen

module decode_control (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] REG_1,
  input  logic [31:0] REG_2,
  output logic [4:0]  RF_SEL_1,
  output logic [4:0]  RF_SEL_2,
  output logic [4:0]  RF_SEL_RD,
  output logic        RF_WR_EN,
  output logic        RF_RESET,
  output logic        RF_SET,
  output logic [1:0]  RF_DATA_IN_MUX_SEL,
  output logic        PC_IN_MUX_SEL,
  output logic        ALU_OP_1_MUX_SEL,
  output logic        ALU_OP_2_MUX_SEL,
  output logic [3:0]  ALU_OPCODE,
  output logic [31:0] immediate,
  output logic        DATA_MEMORY_WR_EN,
  output logic [1:0]  DATA_MEMORY_SIZE_SEL,
  output logic        DATA_MEMORY_SIGN_EXTEND,
  output logic        HALTED
);

  typedef enum logic [1:0] {INIT, SETUP, RUN, HALT} state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;
  localparam logic [3:0] ALU_ADD_C0 = 4'd11;

  state_e state_q, state_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immI, immS, immB, immU, immJ;

  logic        rfWrReq, pcSel, op1Sel, op2Sel, dmWr, dmSext;
  logic [1:0]  rfDataSel, dmSize;
  logic [3:0]  aluOp;
  logic [31:0] imm;
  logic        illegal, sysHalt, haltReq;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign RF_SEL_1  = instruction[19:15];
  assign RF_SEL_2  = instruction[24:20];
  assign RF_SEL_RD = instruction[11:7];

  assign immI = {{20{instruction[31]}}, instruction[31:20]};
  assign immS = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign immB = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                 instruction[11:8], 1'b0};
  assign immU = {instruction[31:12], 12'd0};
  assign immJ = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                 instruction[30:21], 1'b0};

  // Instruction decode. Each opcode fills in the fields it uses; anything an
  // instruction does not use stays at zero. A malformed funct field raises
  // 'illegal', which collapses the whole decode to a NOP afterwards.
  always_comb begin
    rfWrReq   = 1'b0;
    rfDataSel = 2'd0;
    pcSel     = 1'b0;
    op1Sel    = 1'b0;
    op2Sel    = 1'b0;
    aluOp     = ALU_ADD;
    imm       = 32'd0;
    dmWr      = 1'b0;
    dmSize    = 2'd0;
    dmSext    = 1'b0;
    illegal   = 1'b0;
    sysHalt   = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        rfWrReq = 1'b1; rfDataSel = 2'd1; op1Sel = 1'b1; op2Sel = 1'b1;
        // Shift immediates keep the funct7 field in bits [11:5]; the ALU only
        // looks at the low five bits, so the plain I immediate is passed on.
        imm = immI;
        case (funct3)
          3'b000: aluOp = ALU_ADD;
          3'b001: begin aluOp = ALU_SLL; illegal = (funct7 != 7'd0); end
          3'b010: aluOp = ALU_SLT;
          3'b011: aluOp = ALU_SLTU;
          3'b100: aluOp = ALU_XOR;
          3'b101: begin
            aluOp   = funct7[5] ? ALU_SRA : ALU_SRL;
            illegal = ((funct7 & 7'b1011111) != 7'd0);
          end
          3'b110: aluOp = ALU_OR;
          3'b111: aluOp = ALU_AND;
        endcase
      end
      OPC_OP: begin
        rfWrReq = 1'b1; rfDataSel = 2'd1; op1Sel = 1'b1;
        // Only ADD/SUB and SRL/SRA have an alternate encoding with funct7[5].
        illegal = !((funct7 == 7'd0) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        case (funct3)
          3'b000: aluOp = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001: aluOp = ALU_SLL;
          3'b010: aluOp = ALU_SLT;
          3'b011: aluOp = ALU_SLTU;
          3'b100: aluOp = ALU_XOR;
          3'b101: aluOp = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: aluOp = ALU_OR;
          3'b111: aluOp = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        rfWrReq = 1'b1; rfDataSel = 2'd1; op2Sel = 1'b1; imm = immU;
        aluOp = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        rfWrReq = 1'b1; rfDataSel = 2'd1; op2Sel = 1'b1; imm = immU;
      end
      OPC_JAL: begin
        rfWrReq = 1'b1; pcSel = 1'b1; op2Sel = 1'b1; imm = immJ;
      end
      OPC_JALR: begin
        rfWrReq = 1'b1; pcSel = 1'b1; op1Sel = 1'b1; op2Sel = 1'b1;
        imm = immI; aluOp = ALU_ADD_C0;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        // The ALU always forms the target PC+imm; the compare below only
        // decides whether the PC mux takes it.
        op2Sel = 1'b1; imm = immB;
        case (funct3)
          3'b000: pcSel = (REG_1 == REG_2);
          3'b001: pcSel = (REG_1 != REG_2);
          3'b100: pcSel = ($signed(REG_1) <  $signed(REG_2));
          3'b101: pcSel = ($signed(REG_1) >= $signed(REG_2));
          3'b110: pcSel = (REG_1 <  REG_2);
          3'b111: pcSel = (REG_1 >= REG_2);
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        rfWrReq = 1'b1; rfDataSel = 2'd2; op1Sel = 1'b1; op2Sel = 1'b1;
        imm = immI; dmSize = funct3[1:0]; dmSext = !funct3[2];
        illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
      end
      OPC_STORE: begin
        dmWr = 1'b1; op1Sel = 1'b1; op2Sel = 1'b1; imm = immS;
        dmSize = funct3[1:0];
        illegal = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if ((instruction == 32'h0000_0073) || (instruction == 32'h0010_0073))
          sysHalt = 1'b1;
        else
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      rfWrReq   = 1'b0;
      rfDataSel = 2'd0;
      pcSel     = 1'b0;
      op1Sel    = 1'b0;
      op2Sel    = 1'b0;
      aluOp     = ALU_ADD;
      imm       = 32'd0;
      dmWr      = 1'b0;
      dmSize    = 2'd0;
      dmSext    = 1'b0;
    end
  end

`ifdef DECODE_CONTROL_ILLEGAL_HALT_EN
  assign haltReq = sysHalt || illegal;
`else
  assign haltReq = sysHalt;
`endif

  // Output stage. Only RUN lets the decode through; every other state holds
  // the PC (PC + 0 via the ALU) with all writes off.
  always_comb begin
    HALTED   = (state_q == HALT);
    RF_RESET = (state_q == INIT);
    RF_SET   = (state_q == SETUP);
    if (state_q == RUN) begin
      RF_WR_EN                = rfWrReq && (instruction[11:7] != 5'd0);
      RF_DATA_IN_MUX_SEL      = rfDataSel;
      PC_IN_MUX_SEL           = pcSel;
      ALU_OP_1_MUX_SEL        = op1Sel;
      ALU_OP_2_MUX_SEL        = op2Sel;
      ALU_OPCODE              = aluOp;
      immediate               = imm;
      DATA_MEMORY_WR_EN       = dmWr;
      DATA_MEMORY_SIZE_SEL    = dmSize;
      DATA_MEMORY_SIGN_EXTEND = dmSext;
    end else begin
      RF_WR_EN                = 1'b0;
      RF_DATA_IN_MUX_SEL      = 2'd0;
      PC_IN_MUX_SEL           = 1'b1;
      ALU_OP_1_MUX_SEL        = 1'b0;
      ALU_OP_2_MUX_SEL        = 1'b1;
      ALU_OPCODE              = ALU_ADD;
      immediate               = 32'd0;
      DATA_MEMORY_WR_EN       = 1'b0;
      DATA_MEMORY_SIZE_SEL    = 2'd0;
      DATA_MEMORY_SIGN_EXTEND = 1'b0;
    end
  end

  // Next state: start-up walks INIT -> SETUP -> RUN; HALT is left only by reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:  state_d = SETUP;
      SETUP: state_d = RUN;
      RUN:   state_d = haltReq ? HALT : RUN;
      HALT:  state_d = HALT;
    endcase
  end

  // State register with asynchronous return to INIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= INIT;
    else          state_q <= state_d;
  end

endmodule

// File: tb/tb_decode_control.sv
// tb_decode_control
// Self-checking bench for decode_control. Random RV32I instructions are built
// from chosen field values (register numbers, immediate integers, funct codes)
// and the expected control word is derived from those choices, not by
// decoding the instruction bits again. Directed scenarios cover start-up,
// halting and asynchronous reset.

module tb_decode_control;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instruction, REG_1, REG_2;
  logic [4:0]  RF_SEL_1, RF_SEL_2, RF_SEL_RD;
  logic        RF_WR_EN, RF_RESET, RF_SET;
  logic [1:0]  RF_DATA_IN_MUX_SEL;
  logic        PC_IN_MUX_SEL, ALU_OP_1_MUX_SEL, ALU_OP_2_MUX_SEL;
  logic [3:0]  ALU_OPCODE;
  logic [31:0] immediate;
  logic        DATA_MEMORY_WR_EN;
  logic [1:0]  DATA_MEMORY_SIZE_SEL;
  logic        DATA_MEMORY_SIGN_EXTEND, HALTED;

  int checks = 0;
  int errors = 0;

  typedef logic [45:0] ctrl_t;

  always #5 clock = ~clock;

  decode_control dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction),
    .REG_1(REG_1), .REG_2(REG_2),
    .RF_SEL_1(RF_SEL_1), .RF_SEL_2(RF_SEL_2), .RF_SEL_RD(RF_SEL_RD),
    .RF_WR_EN(RF_WR_EN), .RF_RESET(RF_RESET), .RF_SET(RF_SET),
    .RF_DATA_IN_MUX_SEL(RF_DATA_IN_MUX_SEL), .PC_IN_MUX_SEL(PC_IN_MUX_SEL),
    .ALU_OP_1_MUX_SEL(ALU_OP_1_MUX_SEL), .ALU_OP_2_MUX_SEL(ALU_OP_2_MUX_SEL),
    .ALU_OPCODE(ALU_OPCODE), .immediate(immediate),
    .DATA_MEMORY_WR_EN(DATA_MEMORY_WR_EN),
    .DATA_MEMORY_SIZE_SEL(DATA_MEMORY_SIZE_SEL),
    .DATA_MEMORY_SIGN_EXTEND(DATA_MEMORY_SIGN_EXTEND), .HALTED(HALTED)
  );

  // Expected control word, packed in a fixed field order for compact compares.
  function automatic ctrl_t pack(input logic wr, input logic [1:0] data,
                                 input logic pc, input logic o1, input logic o2,
                                 input logic [3:0] alu, input logic [31:0] imm,
                                 input logic dm, input logic [1:0] size,
                                 input logic sext);
    return {wr, data, pc, o1, o2, alu, imm, dm, size, sext};
  endfunction

  function automatic ctrl_t observed();
    return {RF_WR_EN, RF_DATA_IN_MUX_SEL, PC_IN_MUX_SEL, ALU_OP_1_MUX_SEL,
            ALU_OP_2_MUX_SEL, ALU_OPCODE, immediate, DATA_MEMORY_WR_EN,
            DATA_MEMORY_SIZE_SEL, DATA_MEMORY_SIGN_EXTEND};
  endfunction

  function automatic ctrl_t holdWord();
    return pack(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 1'b0, 2'd0, 1'b0);
  endfunction

  function automatic ctrl_t nopWord();
    return pack(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 2'd0, 1'b0);
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Reset and walk through start-up to RUN without checking.
  task automatic bringUp();
    instruction = 32'h0000_0013;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    instruction = 32'h0050_0093;
    REG_1 = 32'd0; REG_2 = 32'd0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({RF_RESET, RF_SET, RF_WR_EN, HALTED} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_asserted: got %b want 1000 (RESET,SET,WR,HALTED)",
               {RF_RESET, RF_SET, RF_WR_EN, HALTED});
    end
    checks++;
    if (observed() !== holdWord()) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %h want %h", observed(), holdWord());
    end
    step();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({RF_RESET, RF_SET} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL init_after_release: got %b want 10", {RF_RESET, RF_SET});
    end
    step();
    checks++;
    if ({RF_RESET, RF_SET, RF_WR_EN} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL setup_state: got %b want 010", {RF_RESET, RF_SET, RF_WR_EN});
    end
    step();
    checks++;
    if ({RF_RESET, RF_SET, RF_WR_EN, HALTED} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL run_state: got %b want 0010", {RF_RESET, RF_SET, RF_WR_EN, HALTED});
    end
  endtask

  task automatic test_directed();
    ctrl_t exp;
    instruction = 32'h0050_0093;
    #1;
    exp = pack(1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h5, 1'b0, 2'd0, 1'b0);
    checks++;
    if (observed() !== exp || RF_SEL_RD !== 5'd1) begin
      errors++;
      $display("[TB] FAIL addi: got %h rd %0d want %h rd 1", observed(), RF_SEL_RD, exp);
    end
    instruction = 32'h0000_0013;
    #1;
    exp = pack(1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h0, 1'b0, 2'd0, 1'b0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL addi_x0: got %h want %h", observed(), exp);
    end
    instruction = 32'hFE20_8CE3; REG_1 = 32'd7; REG_2 = 32'd7;
    #1;
    exp = pack(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 32'hFFFF_FFF8, 1'b0, 2'd0, 1'b0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL beq_taken: got %h want %h", observed(), exp);
    end
    REG_2 = 32'd8;
    #1;
    exp = pack(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 32'hFFFF_FFF8, 1'b0, 2'd0, 1'b0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL beq_not_taken: got %h want %h", observed(), exp);
    end
    instruction = 32'h0020_A623;
    #1;
    exp = pack(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0, 32'hC, 1'b1, 2'd2, 1'b0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL sw: got %h want %h", observed(), exp);
    end
    instruction = 32'hFFF0_C183;
    #1;
    exp = pack(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0, 2'd0, 1'b0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL lbu: got %h want %h", observed(), exp);
    end
    // SLL with funct7=0x20 is not a valid encoding: it must do nothing.
    instruction = 32'h4000_10B3;
    #1;
    checks++;
    if (observed() !== nopWord()) begin
      errors++;
      $display("[TB] FAIL bad_funct7_nop: got %h want %h", observed(), nopWord());
    end
  endtask

  task automatic test_random(input int n);
    int aluTab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int brF3[6]   = '{0, 1, 4, 5, 6, 7};
    int ldF3[5]   = '{0, 1, 2, 4, 5};
    for (int i = 0; i < n; i++) begin
      logic [31:0] ins, iv, r1, r2;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [3:0]  alu;
      logic        taken, alt;
      int          imm, kind;
      ctrl_t       exp;
      step();
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      r1  = $urandom;
      r2  = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
      imm = int'($urandom_range(0, 4095)) - 2048;
      iv  = imm;
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: begin
          f3  = 3'($urandom_range(0, 7));
          alu = 4'(aluTab[f3]);
          if (f3 == 3'd1) begin
            imm = int'($urandom_range(0, 31));
          end else if (f3 == 3'd5) begin
            alt = 1'($urandom_range(0, 1));
            imm = (alt ? 1024 : 0) + int'($urandom_range(0, 31));
            alu = alt ? 4'd7 : 4'd6;
          end
          iv  = imm;
          ins = {iv[11:0], rs1, f3, rd, 7'h13};
          exp = pack(rd != 0, 2'd1, 1'b0, 1'b1, 1'b1, alu, iv, 1'b0, 2'd0, 1'b0);
        end
        1: begin
          f3  = 3'($urandom_range(0, 7));
          alt = ((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1);
          alu = 4'(aluTab[f3]);
          if (alt) alu = (f3 == 3'd0) ? 4'd1 : 4'd7;
          ins = {alt ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
          exp = pack(rd != 0, 2'd1, 1'b0, 1'b1, 1'b0, alu, 32'd0, 1'b0, 2'd0, 1'b0);
        end
        2, 3: begin
          iv  = $urandom;
          ins = {iv[19:0], rd, (kind == 2) ? 7'h37 : 7'h17};
          exp = pack(rd != 0, 2'd1, 1'b0, 1'b0, 1'b1, (kind == 2) ? 4'd10 : 4'd0,
                     {iv[19:0], 12'd0}, 1'b0, 2'd0, 1'b0);
        end
        4: begin
          imm = (int'($urandom_range(0, 20'hFFFFF)) - (1 << 19)) * 2;
          iv  = imm;
          ins = {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'h6F};
          exp = pack(rd != 0, 2'd0, 1'b1, 1'b0, 1'b1, 4'd0, iv, 1'b0, 2'd0, 1'b0);
        end
        5: begin
          ins = {iv[11:0], rs1, 3'b000, rd, 7'h67};
          exp = pack(rd != 0, 2'd0, 1'b1, 1'b1, 1'b1, 4'd11, iv, 1'b0, 2'd0, 1'b0);
        end
        6: begin
          f3  = 3'(brF3[$urandom_range(0, 5)]);
          imm = imm * 2;
          iv  = imm;
          case (f3)
            3'd0:    taken = (r1 == r2);
            3'd1:    taken = (r1 != r2);
            3'd4:    taken = ($signed(r1) < $signed(r2));
            3'd5:    taken = !($signed(r1) < $signed(r2));
            3'd6:    taken = (r1 < r2);
            default: taken = !(r1 < r2);
          endcase
          ins = {iv[12], iv[10:5], rs2, rs1, f3, iv[4:1], iv[11], 7'h63};
          exp = pack(1'b0, 2'd0, taken, 1'b0, 1'b1, 4'd0, iv, 1'b0, 2'd0, 1'b0);
        end
        7: begin
          f3  = 3'(ldF3[$urandom_range(0, 4)]);
          ins = {iv[11:0], rs1, f3, rd, 7'h03};
          exp = pack(rd != 0, 2'd2, 1'b0, 1'b1, 1'b1, 4'd0, iv, 1'b0,
                     2'(f3 % 4), f3 < 3'd4);
        end
        8: begin
          f3  = 3'($urandom_range(0, 2));
          ins = {iv[11:5], rs2, rs1, f3, iv[4:0], 7'h23};
          exp = pack(1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd0, iv, 1'b1, f3[1:0], 1'b0);
        end
        default: begin
          ins = {4'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 13'd0, 7'h0F};
          exp = nopWord();
        end
      endcase
      instruction = ins; REG_1 = r1; REG_2 = r2;
      #1;
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("[TB] FAIL random_ctrl kind %0d ins %h: got %h want %h",
                 kind, ins, observed(), exp);
      end
      checks++;
      if ({RF_SEL_1, RF_SEL_2, RF_SEL_RD, HALTED, RF_RESET, RF_SET} !==
          {ins[19:15], ins[24:20], ins[11:7], 3'b000}) begin
        errors++;
        $display("[TB] FAIL random_sel ins %h: got %h want %h", ins,
                 {RF_SEL_1, RF_SEL_2, RF_SEL_RD, HALTED, RF_RESET, RF_SET},
                 {ins[19:15], ins[24:20], ins[11:7], 3'b000});
      end
    end
  endtask

  task automatic test_illegal();
    logic expHalt;
`ifdef DECODE_CONTROL_ILLEGAL_HALT_EN
    expHalt = 1'b1;
`else
    expHalt = 1'b0;
`endif
    step();
    instruction = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (observed() !== nopWord()) begin
      errors++;
      $display("[TB] FAIL illegal_nop: got %h want %h", observed(), nopWord());
    end
    step();
    instruction = 32'h0000_0013;
    #1;
    checks++;
    if (HALTED !== expHalt) begin
      errors++;
      $display("[TB] FAIL illegal_halt: got %b want %b", HALTED, expHalt);
    end
    bringUp();
  endtask

  task automatic test_halt(input logic [31:0] haltIns);
    step();
    instruction = haltIns;
    #1;
    checks++;
    if (observed() !== nopWord() || HALTED !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_cycle %h: got %h halted %b want %h halted 0",
               haltIns, observed(), HALTED, nopWord());
    end
    for (int c = 0; c < 3; c++) begin
      step();
      instruction = (c == 1) ? 32'h0020_A623 : 32'h0050_0093;
      #1;
      checks++;
      if (observed() !== holdWord() || HALTED !== 1'b1) begin
        errors++;
        $display("[TB] FAIL halted_hold %0d: got %h halted %b want %h halted 1",
                 c, observed(), HALTED, holdWord());
      end
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({RF_RESET, HALTED, RF_WR_EN} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL async_reset_from_halt: got %b want 100",
               {RF_RESET, HALTED, RF_WR_EN});
    end
    step();
    reset_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset_mid_setup();
    instruction = 32'h0050_0093;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({RF_RESET, RF_SET} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_mid_setup: got %b want 10", {RF_RESET, RF_SET});
    end
    step();
    reset_n = 1'b1;
    step();
    step();
    checks++;
    if ({RF_RESET, RF_SET, RF_WR_EN} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL run_after_setup_reset: got %b want 001",
               {RF_RESET, RF_SET, RF_WR_EN});
    end
  endtask

  initial begin
    instruction = 32'h0000_0013;
    REG_1 = 32'd0;
    REG_2 = 32'd0;
    reset_n = 1'b1;
    test_reset();
    test_directed();
    test_random(300);
    test_illegal();
    test_halt(32'h0000_0073);
    test_halt(32'h0010_0073);
    test_reset_mid_setup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
